prelude_ctrl: RTL
=================

Name: prelude_ctrl

Overview:
Instruction sequencer for the Prelude 8-bit core. It is the producer side of the ALU interface: it accepts instruction bytes from the fetch unit, decodes them, and drives alu_op/alu_a/alu_b to the combinational ALU. It captures the ALU result and owns register file r0–r5, the program counter, and the byte-wide I/O port handshakes.

Parameters:
RESET_PC, 8'h00, pc value loaded at reset.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
instr_valid  in  1  fetch has an instruction byte
instr  in  8  instruction byte
instr_ready  out  1  controller accepts instr this cycle
pc  out  8  address of next instruction
pc_load  out  1  one-cycle pulse; fetch flushes and restarts at pc
alu_op  out  6  to ALU; always {3'b000, op}
alu_a  out  8  to ALU operand A (r1)
alu_b  out  8  to ALU operand B (r2)
alu_out  in  8  ALU result, combinational from alu_op/a/b
in_data  in  8  input port byte
in_valid  in  1  input byte present
in_ready  out  1  controller consumes in_data
out_data  out  8  output port byte
out_valid  out  1  out_data valid
out_ready  in  1  sink accepts out_data
halted  out  1  illegal-op trap (see Optional Feature)

Behaviour:
- Reset (async, active-high): r0–r5=0, pc=RESET_PC, pc_load=0, alu_op/alu_a/alu_b=0, out_data=0, out_valid=0, halted=0, FSM=S_FETCH. Reset mid-operation abandons the instruction and drops out_valid immediately.
- FSM states: S_FETCH, S_EXEC, S_IN, S_OUT.
- instr_ready=1 only in S_FETCH and not halted. in_ready=1 only in S_IN. Accept = instr_valid&instr_ready; latch instr, go to S_EXEC.
- Decode by instr[7:6]:
  - 00 IMM: r0 <= {2'b00, instr[5:0]}.
  - 01 CALC: at accept, register alu_op={3'b000,instr[2:0]}, alu_a=r1, alu_b=r2. In S_EXEC, r3 <= alu_out at end of cycle. alu_op/a/b change only on CALC accept.
  - 10 COPY: src=instr[5:3], dst=instr[2:0]; indices 0–5 are r0–r5, 6 is the I/O port, 7 is the null register.
    - src 6: go to S_IN and wait for in_valid; the byte is read on in_valid&in_ready.
    - dst 6: go to S_OUT; out_data <= value, out_valid=1, both held stable until out_ready; clear out_valid on handshake.
    - src 6 with dst 6 passes S_IN, then S_OUT.
    - src 7 reads 8'h00; dst 7 discards the value.
  - 11 COND: test the r3 value at accept, by instr[2:0]: 000 never, 001 ==0, 010 <0 signed, 011 <=0, 100 always, 101 !=0, 110 >=0, 111 >0. If true: pc <= r0, pc_load=1 for one cycle in S_EXEC.
- Retire: end of S_EXEC, or the final handshake of S_IN/S_OUT. Then return to S_FETCH. Non-taken retire sets pc <= pc+1, mod 256 (255 wraps to 0).
- Throughput: 2 cycles per instruction minimum; I/O waits add cycles without bound.
- Result visibility: a CALC accepted at cycle N has r3 valid from N+2. The next instruction always sees the prior result; there are no hazards.
- Fetch ignores instr bytes presented while instr_ready=0.

Optional Feature:
Macro PRELUDE_ILLEGAL_TRAP_EN.
- Defined: CALC with op 3'b110 is legal. CALC op 3'b111 (unimplemented SHL), or COPY using index 7 as src or dst, is an illegal op.
  - An illegal op sets halted=1 (sticky) at the end of S_EXEC, with no register, pc or port update.
  - instr_ready is then held 0 until reset.
- Undefined: halted is tied 0. Op 111 writes alu_out (ALU returns 0) to r3. Index 7 behaves as the null register.

Test Plan:
1. Reset, then stream IMM 0x05 and COPY r0→r1 (0x81) -> r0=5, r1=5, pc=2, instr_ready pattern 1,0,1,0.
2. r1=0x05, r2=0x03, CALC ADD (0x44) -> alu_op=6'b000100, alu_a=5, alu_b=3, r3=0x08 two cycles after accept; then SUB (0x45) -> r3=0x02.
3. r3=0x80, r0=0x20, COND <0 (0xC2) -> pc_load pulse, pc=0x20. COND >0 (0xC7) with r3=0x80 -> not taken, pc+1. pc=0xFF non-taken -> pc=0x00.
4. COPY r3→out (0x9E), out_ready low 5 cycles -> out_valid high and out_data stable for 5 cycles, instr_ready=0; retire on the cycle out_ready goes high.
5. COPY in→r2 (0xB2), in_valid after 3 cycles with 0xA7 -> r2=0xA7. Assert rst while waiting in S_OUT -> out_valid=0 immediately, pc=RESET_PC.
6. With PRELUDE_ILLEGAL_TRAP_EN: CALC 0x47 -> halted=1, r3 unchanged, instr_ready stays 0. Without the macro -> r3=0x00, halted=0.

Source files
------------

// File: rtl/prelude_ctrl.sv
// Prelude 8-bit core instruction sequencer: decodes fetched bytes, drives the ALU, owns r0-r5, pc and I/O ports.
// Optional illegal-op trap is enabled with `define PRELUDE_ILLEGAL_TRAP_EN.
module prelude_ctrl #(
   parameter logic [7:0] RESET_PC = 8'h00
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       instr_valid,
   input  logic [7:0] instr,
   output logic       instr_ready,
   output logic [7:0] pc,
   output logic       pc_load,
   output logic [5:0] alu_op,
   output logic [7:0] alu_a,
   output logic [7:0] alu_b,
   input  logic [7:0] alu_out,
   input  logic [7:0] in_data,
   input  logic       in_valid,
   output logic       in_ready,
   output logic [7:0] out_data,
   output logic       out_valid,
   input  logic       out_ready,
   output logic       halted
);

   // state   | meaning
   // S_FETCH | waiting for an instruction byte (instr_ready high unless halted)
   // S_EXEC  | latched instruction executes; simple ops retire here
   // S_IN    | COPY from port: waiting for in_valid
   // S_OUT   | COPY to port: out_valid held until out_ready
   typedef enum logic [1:0] {S_FETCH, S_EXEC, S_IN, S_OUT} state_t;

   state_t     state, state_nxt;
   logic [7:0] rf [0:5];
   logic [7:0] ir;
   logic       taken;
   logic       accept, retire, illegal;
   logic [1:0] cls;
   logic [2:0] src, dst;
   logic [7:0] src_val;

   assign cls    = ir[7:6];
   assign src    = ir[5:3];
   assign dst    = ir[2:0];
   assign accept = instr_valid & instr_ready;

   function automatic logic cond_true(input logic [2:0] code, input logic [7:0] v);
      logic z, n;
      z = (v == 8'h00);
      n = v[7];
      case (code)
         3'b000:  return 1'b0;
         3'b001:  return z;
         3'b010:  return n;
         3'b011:  return n | z;
         3'b100:  return 1'b1;
         3'b101:  return ~z;
         3'b110:  return ~n;
         default: return ~n & ~z;
      endcase
   endfunction

   // Index 6 (port) is never read through this path; index 7 is the null register.
   always_comb begin
      src_val = 8'h00;
      case (src)
         3'd0:    src_val = rf[0];
         3'd1:    src_val = rf[1];
         3'd2:    src_val = rf[2];
         3'd3:    src_val = rf[3];
         3'd4:    src_val = rf[4];
         3'd5:    src_val = rf[5];
         default: src_val = 8'h00;
      endcase
   end

`ifdef PRELUDE_ILLEGAL_TRAP_EN
   assign illegal = (cls == 2'b01 && ir[2:0] == 3'b111) ||
                    (cls == 2'b10 && (src == 3'd7 || dst == 3'd7));

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         halted <= 1'b0;
      else if (state == S_EXEC && illegal)
         halted <= 1'b1;
   end
`else
   assign illegal = 1'b0;
   assign halted  = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= S_FETCH;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt   = state;
      instr_ready = 1'b0;
      in_ready    = 1'b0;
      retire      = 1'b0;
      case (state)
         S_FETCH: begin
            instr_ready = ~halted;
            if (instr_valid && !halted)
               state_nxt = S_EXEC;
         end
         S_EXEC: begin
            if (illegal)
               state_nxt = S_FETCH;
            else if (cls == 2'b10 && src == 3'd6)
               state_nxt = S_IN;
            else if (cls == 2'b10 && dst == 3'd6)
               state_nxt = S_OUT;
            else begin
               state_nxt = S_FETCH;
               retire    = 1'b1;
            end
         end
         S_IN: begin
            in_ready = 1'b1;
            if (in_valid) begin
               if (dst == 3'd6)
                  state_nxt = S_OUT;
               else begin
                  state_nxt = S_FETCH;
                  retire    = 1'b1;
               end
            end
         end
         S_OUT: begin
            if (out_ready) begin
               state_nxt = S_FETCH;
               retire    = 1'b1;
            end
         end
         default: state_nxt = S_FETCH;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 6; i++)
            rf[i] <= 8'h00;
         ir        <= 8'h00;
         taken     <= 1'b0;
         pc        <= RESET_PC;
         pc_load   <= 1'b0;
         alu_op    <= 6'd0;
         alu_a     <= 8'h00;
         alu_b     <= 8'h00;
         out_data  <= 8'h00;
         out_valid <= 1'b0;
      end else begin
         pc_load <= 1'b0;

         if (accept) begin
            ir    <= instr;
            taken <= 1'b0;
            if (instr[7:6] == 2'b01) begin
               alu_op <= {3'b000, instr[2:0]};
               alu_a  <= rf[1];
               alu_b  <= rf[2];
            end
            // Branch resolves at accept so pc is already the target while pc_load is high.
            if (instr[7:6] == 2'b11 && cond_true(instr[2:0], rf[3])) begin
               taken   <= 1'b1;
               pc      <= rf[0];
               pc_load <= 1'b1;
            end
         end

         if (state == S_EXEC && !illegal) begin
            case (cls)
               2'b00: rf[0] <= {2'b00, ir[5:0]};
               2'b01: rf[3] <= alu_out;
               2'b10: begin
                  if (src != 3'd6) begin
                     if (dst < 3'd6)
                        rf[dst] <= src_val;
                     else if (dst == 3'd6) begin
                        out_data  <= src_val;
                        out_valid <= 1'b1;
                     end
                  end
               end
               default: ;
            endcase
         end

         if (state == S_IN && in_valid) begin
            if (dst < 3'd6)
               rf[dst] <= in_data;
            else if (dst == 3'd6) begin
               out_data  <= in_data;
               out_valid <= 1'b1;
            end
         end

         if (state == S_OUT && out_ready)
            out_valid <= 1'b0;

         if (retire && !taken)
            pc <= pc + 8'd1;
      end
   end

endmodule
